reduce_and8_checker: RTL and testbench

Self-checking stimulus/response engine for the icestick 8-bit reduce-AND datapath. It sits at the opposite end of the reducer's interface: it drives every one of the 2^WIDTH input patterns onto the reducer's input bus and samples the reducer's 1-bit result. It compares each result against an internally computed expected value and reports pass/fail, the error count and the first failing pattern. It is used for on-board bring-up and simulation sign-off of reduction blocks.

---
 rtl/reduce_and8_checker_if.sv | 42 ++++
 rtl/reduce_and8_checker.sv | 180 ++++++++++++++++++
 tb/tb_reduce_and8_checker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/reduce_and8_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : reduce_and8_checker_if
// Brief    : Pattern/response bus and sweep status between the checker and
//            the reduce-AND block under test.
// Revision : 1.0 - initial release
// ============================================================================
interface reduce_and8_checker_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] O;
    logic             I;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH:0]   err_count;
    logic [WIDTH-1:0] first_fail;

    modport master (
        input  start,
        input  I,
        output O,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail
    );

    modport slave (
        output start,
        output I,
        input  O,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail
    );
endinterface
`default_nettype wire

// File: rtl/reduce_and8_checker.sv
`default_nettype none
// ============================================================================
// Module   : reduce_and8_checker
// Brief    : Exhaustive stimulus/response checker for a WIDTH-bit reduce-AND
//            block with LAT cycles of response latency.
// Revision : 1.0 - initial release
// ============================================================================
module reduce_and8_checker #(
    parameter int WIDTH = 8,
    parameter int LAT   = 0
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    reduce_and8_checker_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_ones       = '1;
    localparam logic [WIDTH-1:0] c_cnt_one    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]       c_drain_last = 2'(LAT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_start_sweep;
    logic             w_issue;
    logic [WIDTH-1:0] w_o;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_cnt;
    logic [1:0]       r_drain_cnt;
    logic [WIDTH:0]   r_err_count;
    logic [WIDTH-1:0] r_first_fail;
    logic             r_pass;

    logic             w_cmp_valid;
    logic             w_cmp_exp;
    logic [WIDTH-1:0] w_cmp_pat;
    logic             w_mismatch;
    logic [WIDTH:0]   w_err_next;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_start_sweep = 1'b0;
        w_issue       = 1'b0;
        w_o           = '0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state  = S_RUN;
                    w_start_sweep = 1'b1;
                end
            end
            S_RUN: begin
                w_issue = 1'b1;
                w_o     = r_cnt;
                w_busy  = 1'b1;
                if (r_cnt == c_ones) begin
                    w_next_state = (LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Hold all-ones so a lagging reducer still sees the last pattern
                w_o    = c_ones;
                w_busy = 1'b1;
                if (r_drain_cnt == c_drain_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_next_state  = S_RUN;
                    w_start_sweep = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    generate
        if (LAT == 0) begin : g_no_pipe
            assign w_cmp_valid = w_issue;
            assign w_cmp_exp   = &r_cnt;
            assign w_cmp_pat   = r_cnt;
        end else begin : g_pipe
            logic [LAT-1:0]   r_pv;
            logic [LAT-1:0]   r_pe;
            logic [WIDTH-1:0] r_pp [LAT];

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    r_pv <= '0;
                    r_pe <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        r_pp[i] <= '0;
                    end
                end else if (w_start_sweep) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_issue;
                    r_pe[0] <= &r_cnt;
                    r_pp[0] <= r_cnt;
                    for (int i = 1; i < LAT; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pe[i] <= r_pe[i-1];
                        r_pp[i] <= r_pp[i-1];
                    end
                end
            end

            assign w_cmp_valid = r_pv[LAT-1];
            assign w_cmp_exp   = r_pe[LAT-1];
            assign w_cmp_pat   = r_pp[LAT-1];
        end
    endgenerate

    assign w_mismatch = w_cmp_valid && (w_cmp_exp != bus.I);
    assign w_err_next = r_err_count + {{WIDTH{1'b0}}, w_mismatch};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt        <= '0;
            r_drain_cnt  <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
        end else if (w_start_sweep) begin
            r_cnt        <= '0;
            r_drain_cnt  <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
        end else begin
            if (r_state == S_RUN) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 2'd1;
            end
            if (w_mismatch) begin
                r_err_count <= w_err_next;
                if (r_err_count == '0) begin
                    r_first_fail <= w_cmp_pat;
                end
            end
            // Uses the post-compare count so the final pattern is included
            if ((w_next_state == S_DONE) && (r_state != S_DONE)) begin
                r_pass <= (w_err_next == '0);
            end
        end
    end

    assign bus.O          = w_o;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err_count;
    assign bus.first_fail = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_reduce_and8_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_reduce_and8_checker
// Brief    : Directed bench for reduce_and8_checker at LAT=0 and LAT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reduce_and8_checker;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_errors;
    int   mode0;
    int   mode2;
    int   sel;

    reduce_and8_checker_if #(.WIDTH(8)) if0 ();
    reduce_and8_checker_if #(.WIDTH(8)) if2 ();

    reduce_and8_checker #(.WIDTH(8), .LAT(0)) dut0 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (if0)
    );

    reduce_and8_checker #(.WIDTH(8), .LAT(2)) dut2 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (if2)
    );

    // Reducer models: mode0 0=ideal AND8, 1=tied 0, 2=tied 1; mode2 0=2 regs, 1=1 reg
    logic r_m1;
    logic r_m2;
    always @(posedge CLK) begin
        r_m1 <= &if2.O;
        r_m2 <= r_m1;
    end
    assign if0.I = (mode0 == 0) ? &if0.O : (mode0 == 1) ? 1'b0 : 1'b1;
    assign if2.I = (mode2 == 0) ? r_m2 : r_m1;

    logic       s_busy, s_done, s_pass;
    logic [8:0] s_err;
    logic [7:0] s_first, s_o;
    always_comb begin
        s_busy  = (sel == 0) ? if0.busy       : if2.busy;
        s_done  = (sel == 0) ? if0.done       : if2.done;
        s_pass  = (sel == 0) ? if0.pass       : if2.pass;
        s_err   = (sel == 0) ? if0.err_count  : if2.err_count;
        s_first = (sel == 0) ? if0.first_fail : if2.first_fail;
        s_o     = (sel == 0) ? if0.O          : if2.O;
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int   lat;
        int   mode;
        int   exp_err;
        int   exp_first;
        logic exp_pass;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int lat);
        @(negedge CLK);
        if (lat == 0) if0.start = 1'b1;
        else          if2.start = 1'b1;
        @(posedge CLK);
        #1;
        if0.start = 1'b0;
        if2.start = 1'b0;
    endtask

    // Returns the number of edges after the first RUN cycle until done rises
    task automatic run_sweep(input int lat, output int n);
        sel = lat;
        pulse_start(lat);
        check("run_entry_busy", 32'(s_busy), 1);
        check("run_entry_O", 32'(s_o), 0);
        n = 0;
        while (!s_done && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 400) check("sweep_timeout", 32'(n), 32'(256 + lat));
    endtask

    vec_t vecs [5];
    int   n;
    int   k;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mode0     = 0;
        mode2     = 0;
        sel       = 0;
        if0.start = 1'b0;
        if2.start = 1'b0;
        RESET     = 1'b1;

        vecs[0] = '{lat: 0, mode: 0, exp_err: 0,   exp_first: 8'h00, exp_pass: 1'b1};
        vecs[1] = '{lat: 0, mode: 1, exp_err: 1,   exp_first: 8'hFF, exp_pass: 1'b0};
        vecs[2] = '{lat: 0, mode: 2, exp_err: 255, exp_first: 8'h00, exp_pass: 1'b0};
        vecs[3] = '{lat: 2, mode: 0, exp_err: 0,   exp_first: 8'h00, exp_pass: 1'b1};
        vecs[4] = '{lat: 2, mode: 1, exp_err: 1,   exp_first: 8'hFE, exp_pass: 1'b0};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_O", 32'(if0.O), 0);
        check("reset_busy", 32'(if0.busy), 0);
        check("reset_done", 32'(if0.done), 0);
        check("reset_pass", 32'(if0.pass), 0);
        check("reset_err", 32'(if0.err_count), 0);
        check("reset_first", 32'(if0.first_fail), 0);
        check("reset_done_lat2", 32'(if2.done), 0);
        RESET = 1'b0;

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].lat == 0) mode0 = vecs[v].mode;
            else                  mode2 = vecs[v].mode;
            run_sweep(vecs[v].lat, n);
            check($sformatf("v%0d_done_cycle", v), 32'(n), 32'(256 + vecs[v].lat));
            check($sformatf("v%0d_busy", v), 32'(s_busy), 0);
            check($sformatf("v%0d_pass", v), 32'(s_pass), 32'(vecs[v].exp_pass));
            check($sformatf("v%0d_err", v), 32'(s_err), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_first", v), 32'(s_first), 32'(vecs[v].exp_first));
        end

        // Mid-sweep reset with a partial error count, start ignored during RUN
        mode0 = 2;
        sel   = 0;
        pulse_start(0);
        k = 0;
        while (if0.O != 8'd50 && k < 300) begin
            @(posedge CLK);
            #1;
            k++;
        end
        pulse_start(0);
        check("start_ignored_O", 32'(if0.O), 51);
        check("start_ignored_busy", 32'(if0.busy), 1);
        k = 0;
        while (if0.O != 8'd100 && k < 300) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("partial_err_at_100", 32'(if0.err_count), 100);
        #2;
        RESET = 1'b1;
        #1;
        check("abort_O", 32'(if0.O), 0);
        check("abort_busy", 32'(if0.busy), 0);
        check("abort_done", 32'(if0.done), 0);
        check("abort_pass", 32'(if0.pass), 0);
        check("abort_err", 32'(if0.err_count), 0);
        check("abort_first", 32'(if0.first_fail), 0);
        @(negedge CLK);
        RESET = 1'b0;

        mode0 = 0;
        run_sweep(0, n);
        check("clean_done_cycle", 32'(n), 256);
        check("clean_pass", 32'(if0.pass), 1);
        check("clean_err", 32'(if0.err_count), 0);

        // Restart from DONE after a failing sweep
        mode0 = 2;
        run_sweep(0, n);
        check("fail_err", 32'(if0.err_count), 255);
        mode0 = 0;
        pulse_start(0);
        check("restart_err_cleared", 32'(if0.err_count), 0);
        check("restart_done_low", 32'(if0.done), 0);
        check("restart_pass_low", 32'(if0.pass), 0);
        check("restart_busy", 32'(if0.busy), 1);
        k = 0;
        while (!if0.done && k < 400) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("restart_pass", 32'(if0.pass), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
